// File: rtl/fir_mac_ctrl.sv
// fir_mac_ctrl
// ------------
// Sequencer for the 10-tap FIR datapath. Each new-sample strobe runs this sequence:
//   1. shift the delay chain;
//   2. read the TAPS coefficients from the single-port coefficient SRAM, in address order;
//   3. drive the MAC multiply and add/accumulate enables;
//   4. flag the filter result as valid.
// While no run is in progress, a host may take over the SRAM through a coefficient-update
// passthrough.
//
// Optional feature: define FIR_OVERRUN_CNT_EN to add oOverrunCnt, a saturating 8-bit count
// of dropped samples.
//
// Ports
//   iClk12M, iRst          clock, asynchronous active-high reset
//   iEnSample              one-cycle new-sample strobe
//   iCoeffUpdateFlag       level, host requests SRAM ownership
//   iCsnRam/iWrnRam/iAddrRam/iWrDtRam   host SRAM port (active-low controls)
//   oCsnRam/oWrnRam/oAddrRam/oWrDtRam   SpSram port (active-low controls)
//   oEnDelay, oEnMul, oEnAddAcc         delay-chain / MAC enables
//   oValid                 one-cycle filter-result-valid pulse
//   oBusy                  high while a filter run is in progress
//   oOverrun               one-cycle pulse, a sample strobe was dropped
//   oOverrunCnt            (FIR_OVERRUN_CNT_EN only) saturating dropped-sample count
//   oDbgState              current FSM state, for observation only
//
// Strobe semantics: iEnSample carries no handshake. A strobe is accepted only in IDLE or
// DONE. The controller drops a strobe that arrives in SHIFT, RUN or DRAIN, and reports the
// drop with oOverrun on the next cycle. It ignores a strobe that arrives in UPDATE without
// reporting it.

module fir_mac_ctrl #(
    parameter int TAPS    = 10,
    parameter int ADDR_W  = 4,
    parameter int COEFF_W = 16
) (
    input  logic               iClk12M,
    input  logic               iRst,
    input  logic               iEnSample,
    input  logic               iCoeffUpdateFlag,
    input  logic               iCsnRam,
    input  logic               iWrnRam,
    input  logic [ADDR_W-1:0]  iAddrRam,
    input  logic [COEFF_W-1:0] iWrDtRam,
    output logic               oCsnRam,
    output logic               oWrnRam,
    output logic [ADDR_W-1:0]  oAddrRam,
    output logic [COEFF_W-1:0] oWrDtRam,
    output logic               oEnDelay,
    output logic               oEnMul,
    output logic               oEnAddAcc,
    output logic               oValid,
    output logic               oBusy,
    output logic               oOverrun,
`ifdef FIR_OVERRUN_CNT_EN
    output logic [7:0]         oOverrunCnt,
`endif
    output logic [2:0]         oDbgState
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SHIFT  = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4,
        S_UPDATE = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] tap_cnt_q, tap_cnt_d;
    logic              drain_cnt_q, drain_cnt_d;
    logic              en_mul_q, en_mul_d;
    logic              en_add_acc_q, en_add_acc_d;
    logic              overrun_q, overrun_d;

    always_ff @(posedge iClk12M or posedge iRst) begin
        if (iRst) begin
            state_q      <= S_IDLE;
            tap_cnt_q    <= '0;
            drain_cnt_q  <= 1'b0;
            en_mul_q     <= 1'b0;
            en_add_acc_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tap_cnt_q    <= tap_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            en_mul_q     <= en_mul_d;
            en_add_acc_q <= en_add_acc_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tap_cnt_d    = tap_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        overrun_d    = 1'b0;
        oCsnRam      = 1'b1;
        oWrnRam      = 1'b1;
        oAddrRam     = '0;
        oWrDtRam     = '0;
        oEnDelay     = 1'b0;
        oValid       = 1'b0;
        oBusy        = 1'b1;

        case (state_q)
            S_IDLE: begin
                oBusy = 1'b0;
                // A pending sample takes priority over a host update request.
                if (iEnSample) begin
                    state_d = S_SHIFT;
                end else if (iCoeffUpdateFlag) begin
                    state_d = S_UPDATE;
                end
            end
            S_SHIFT: begin
                oEnDelay  = 1'b1;
                tap_cnt_d = '0;
                overrun_d = iEnSample;
                state_d   = S_RUN;
            end
            S_RUN: begin
                oCsnRam   = 1'b0;
                oAddrRam  = tap_cnt_q;
                overrun_d = iEnSample;
                // The counter holds at the last tap; only SHIFT restarts it.
                if (tap_cnt_q == LAST_TAP) begin
                    drain_cnt_d = 1'b0;
                    state_d     = S_DRAIN;
                end else begin
                    tap_cnt_d = tap_cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // Two cycles let the last product reach the accumulator.
                overrun_d = iEnSample;
                if (drain_cnt_q) begin
                    state_d = S_DONE;
                end else begin
                    drain_cnt_d = 1'b1;
                end
            end
            S_DONE: begin
                oValid = 1'b1;
                if (iEnSample) begin
                    state_d = S_SHIFT;
                end else if (iCoeffUpdateFlag) begin
                    state_d = S_UPDATE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_UPDATE: begin
                oBusy    = 1'b0;
                oCsnRam  = iCsnRam;
                oWrnRam  = iWrnRam;
                oAddrRam = iAddrRam;
                oWrDtRam = iWrDtRam;
                if (!iCoeffUpdateFlag) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The SRAM returns a coefficient one cycle after the read. Only filter reads feed
        // the MAC; host reads in UPDATE do not.
        en_mul_d     = (state_q == S_RUN);
        en_add_acc_d = en_mul_q;
    end

    assign oEnMul    = en_mul_q;
    assign oEnAddAcc = en_add_acc_q;
    assign oOverrun  = overrun_q;
    assign oDbgState = state_q;

`ifdef FIR_OVERRUN_CNT_EN
    logic [7:0] overrun_cnt_q, overrun_cnt_d;

    always_comb begin
        overrun_cnt_d = overrun_cnt_q;
        if (overrun_q && (overrun_cnt_q != 8'hFF)) begin
            overrun_cnt_d = overrun_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge iClk12M or posedge iRst) begin
        if (iRst) begin
            overrun_cnt_q <= 8'd0;
        end else begin
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    assign oOverrunCnt = overrun_cnt_q;
`else
    // Without the counter, dropped samples are reported only by the oOverrun pulse.
`endif

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Bench for fir_mac_ctrl.
//
// The reference model describes a run as a timeline. When a sample is accepted at cycle ts,
// each output follows from the phase p = cycle - ts:
//   - oEnDelay at p = 1;
//   - reads of addresses 0..9 at p = 2..11;
//   - oEnMul at p = 3..12, oEnAddAcc at p = 4..13;
//   - oValid at p = 14.
// In update mode the host signals appear on the SRAM port unchanged.

module tb_fir_mac_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_sample = 1'b0;
    logic        flag = 1'b0;
    logic        h_csn = 1'b1;
    logic        h_wrn = 1'b1;
    logic [3:0]  h_addr = 4'd0;
    logic [15:0] h_wrdt = 16'd0;

    logic        oCsnRam, oWrnRam, oEnDelay, oEnMul, oEnAddAcc, oValid, oBusy, oOverrun;
    logic [3:0]  oAddrRam;
    logic [15:0] oWrDtRam;
    logic [2:0]  oDbgState;
`ifdef FIR_OVERRUN_CNT_EN
    logic [7:0]  oOverrunCnt;
`endif

    fir_mac_ctrl #(.TAPS(10), .ADDR_W(4), .COEFF_W(16)) dut (
        .iClk12M(clk),
        .iRst(rst),
        .iEnSample(en_sample),
        .iCoeffUpdateFlag(flag),
        .iCsnRam(h_csn),
        .iWrnRam(h_wrn),
        .iAddrRam(h_addr),
        .iWrDtRam(h_wrdt),
        .oCsnRam(oCsnRam),
        .oWrnRam(oWrnRam),
        .oAddrRam(oAddrRam),
        .oWrDtRam(oWrDtRam),
        .oEnDelay(oEnDelay),
        .oEnMul(oEnMul),
        .oEnAddAcc(oEnAddAcc),
        .oValid(oValid),
        .oBusy(oBusy),
        .oOverrun(oOverrun),
`ifdef FIR_OVERRUN_CNT_EN
        .oOverrunCnt(oOverrunCnt),
`endif
        .oDbgState(oDbgState)
    );

    // Clock
    always #5 clk = ~clk;

    // Counters and model state
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int mode     = 0;    // 0 idle, 1 running, 2 host update
    int ts       = 0;    // cycle on which the current run's sample was accepted
    bit ov_pend  = 1'b0;
    int ovcnt    = 0;
    int valid_cnt  = 0;
    int last_valid = -1;
    int last_ov    = -1;

    localparam logic [27:0] RESET_VEC = 28'hC000000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [27:0] out_vec();
        return {oCsnRam, oWrnRam, oAddrRam, oWrDtRam,
                oEnDelay, oEnMul, oEnAddAcc, oValid, oBusy, oOverrun};
    endfunction

    // One clock cycle: drive inputs, compare at the falling edge, advance the model.
    // The task is entered and left 1 time unit after a rising edge.
    task automatic step(input bit s, input bit f, input bit c, input bit w,
                        input logic [3:0] a, input logic [15:0] d);
        logic [27:0] exp_v;
        int p;
        bit e_csn, e_wrn, e_dl, e_mul, e_add, e_val, e_busy, ov_next;
        logic [3:0]  e_addr;
        logic [15:0] e_dt;
        en_sample = s; flag = f; h_csn = c; h_wrn = w; h_addr = a; h_wrdt = d;
        @(negedge clk);
        e_csn = 1'b1; e_wrn = 1'b1; e_addr = 4'd0; e_dt = 16'd0;
        e_dl = 1'b0; e_mul = 1'b0; e_add = 1'b0; e_val = 1'b0; e_busy = 1'b0;
        if (mode == 1) begin
            p = cyc - ts;
            e_busy = 1'b1;
            e_dl   = (p == 1);
            if (p >= 2 && p <= 11) begin
                e_csn  = 1'b0;
                e_addr = 4'(p - 2);
            end
            e_mul = (p >= 3 && p <= 12);
            e_add = (p >= 4 && p <= 13);
            e_val = (p == 14);
        end else if (mode == 2) begin
            e_csn = c; e_wrn = w; e_addr = a; e_dt = d;
        end
        exp_v = {e_csn, e_wrn, e_addr, e_dt, e_dl, e_mul, e_add, e_val, e_busy, ov_pend};
        check("outputs", 64'(out_vec()), 64'(exp_v));
`ifdef FIR_OVERRUN_CNT_EN
        check("overrun_cnt", 64'(oOverrunCnt), 64'(ovcnt));
`endif
        if (oValid) begin valid_cnt++; last_valid = cyc; end
        if (oOverrun) last_ov = cyc;
        // advance the model
        if (ov_pend && ovcnt < 255) ovcnt++;
        ov_next = 1'b0;
        case (mode)
            0: begin
                if (s) begin mode = 1; ts = cyc; end
                else if (f) mode = 2;
            end
            1: begin
                p = cyc - ts;
                if (p >= 1 && p <= 13) begin
                    if (s) ov_next = 1'b1;
                end else if (p == 14) begin
                    if (s) ts = cyc;
                    else if (f) mode = 2;
                    else mode = 0;
                end
            end
            default: begin
                if (!f) mode = 0;
            end
        endcase
        ov_pend = ov_next;
        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n, input bit f);
        for (int i = 0; i < n; i++) step(1'b0, f, 1'b1, 1'b1, 4'd0, 16'd0);
    endtask

    task automatic reset_mid_cycle();
        en_sample = 1'b0; flag = 1'b0;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", 64'(out_vec()), 64'(RESET_VEC));
`ifdef FIR_OVERRUN_CNT_EN
        check("async_reset_cnt", 64'(oOverrunCnt), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        mode = 0; ov_pend = 1'b0; ovcnt = 0; cyc++;
    endtask

    typedef struct {
        logic        sample;
        logic        csn;
        logic        wrn;
        logic [3:0]  addr;
        logic [15:0] dt;
        logic        e_csn;
        logic        e_wrn;
        logic [3:0]  e_addr;
        logic [15:0] e_dt;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int t0;
        bit rf;
        tbl[0] = '{1'b0, 1'b0, 1'b0, 4'd3, 16'h1234, 1'b0, 1'b0, 4'd3, 16'h1234};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 4'd3, 16'h1234, 1'b0, 1'b0, 4'd3, 16'h1234};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 4'd7, 16'h0000, 1'b0, 1'b1, 4'd7, 16'h0000};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 4'd9, 16'hFFFF, 1'b1, 1'b1, 4'd9, 16'hFFFF};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 4'd0, 16'hBEEF, 1'b0, 1'b0, 4'd0, 16'hBEEF};

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 64'(out_vec()), 64'(RESET_VEC));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        idle(2, 1'b0);

        // A single sample
        valid_cnt = 0; t0 = cyc;
        step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 16'd0);
        idle(16, 1'b0);
        check("single_valid_latency", 64'(last_valid - t0), 64'd14);
        check("single_valid_count", 64'(valid_cnt), 64'd1);

        // A second sample during the run is dropped
        valid_cnt = 0; t0 = cyc;
        step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 16'd0);
        idle(4, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 16'd0);
        idle(12, 1'b0);
        check("overrun_latency", 64'(last_ov - t0), 64'd6);
        check("overrun_valid_count", 64'(valid_cnt), 64'd1);
`ifdef FIR_OVERRUN_CNT_EN
        check("overrun_cnt_one", 64'(oOverrunCnt), 64'd1);
`endif

        // Host update passthrough
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 16'd0);
        for (int i = 0; i < 5; i++) begin
            en_sample = tbl[i].sample; flag = 1'b1;
            h_csn = tbl[i].csn; h_wrn = tbl[i].wrn; h_addr = tbl[i].addr; h_wrdt = tbl[i].dt;
            #1;
            check($sformatf("update_vec%0d", i),
                  64'({oCsnRam, oWrnRam, oAddrRam, oWrDtRam, oBusy, oValid}),
                  64'({tbl[i].e_csn, tbl[i].e_wrn, tbl[i].e_addr, tbl[i].e_dt, 2'b00}));
            step(tbl[i].sample, 1'b1, tbl[i].csn, tbl[i].wrn, tbl[i].addr, tbl[i].dt);
        end
        check("update_no_overrun", 64'(oOverrun), 64'd0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 16'd0);
        idle(2, 1'b0);

        // An update request in mid-run waits for DONE
        t0 = cyc;
        step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 16'd0);
        idle(5, 1'b0);
        idle(10, 1'b1);
        check("midrun_update_valid", 64'(last_valid - t0), 64'd14);
        check("midrun_update_state", 64'(oDbgState), 64'd5);
        idle(2, 1'b0);

        // Sample and update request together: the run goes first
        t0 = cyc;
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 16'd0);
        idle(16, 1'b1);
        check("both_valid_latency", 64'(last_valid - t0), 64'd14);
        idle(2, 1'b0);

        // Reset during a run
        valid_cnt = 0;
        step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 16'd0);
        idle(7, 1'b0);
        reset_mid_cycle();
        idle(10, 1'b0);
        check("reset_no_valid", 64'(valid_cnt), 64'd0);
        t0 = cyc;
        step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 16'd0);
        idle(15, 1'b0);
        check("restart_valid_latency", 64'(last_valid - t0), 64'd14);

        // Random traffic
        rf = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) rf = ~rf;
            step($urandom_range(0, 9) == 0, rf, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 16'($urandom_range(0, 65535)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
